// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encoding and constants shared by the ALU sharing controller
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_DIV = 4'b1011;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational 32-bit ALU; unlisted control codes fall through to add
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_control,
  output logic        zero,
  output logic [31:0] alu_result
);

  always_comb begin
    alu_result = a + b;
    case (alu_control)
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_ADD: alu_result = a + b;
      ALU_XOR: alu_result = a ^ b;
      ALU_MUL: alu_result = a * b;
      ALU_SUB: alu_result = a - b;
      ALU_SLT: alu_result = {31'b0, ($signed(a) < $signed(b))};
      // shift amount comes from the shamt field, not the low bits of b
      ALU_SLL: alu_result = a << b[10:6];
      ALU_SRL: alu_result = a >> b[10:6];
      ALU_SRA: alu_result = $signed(a) >>> b[10:6];
      ALU_DIV: alu_result = (b == '0) ? '0 : a / b;
      ALU_NOR: alu_result = ~(a | b);
      default: alu_result = a + b;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one multi-cycle ALU between two requesters
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic        busy
);

  function automatic logic [3:0] lat_sel(input logic [3:0] op);
    case (op)
      ALU_MUL: return 4'(MUL_CYCLES);
      ALU_DIV: return 4'(DIV_CYCLES);
      default: return 4'd1;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        grant;
  logic [31:0] alu_res;
  logic        alu_zero;

  ALU u_alu (
    .a          (a_q),
    .b          (b_q),
    .alu_control(op_q),
    .zero       (alu_zero),
    .alu_result (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // a lone requester always wins; prio only breaks ties
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
    else                                grant = prio_q;

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = !grant;
          req1_ready = grant;
          owner_d    = grant;
          prio_d     = !grant;
          a_d        = grant ? req1_a  : req0_a;
          b_d        = grant ? req1_b  : req0_b;
          op_d       = grant ? req1_op : req0_op;
          cnt_d      = lat_sel(op_d);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (op_q == ALU_DIV && b_q == '0) begin
            result_d = DIV0_RESULT;
            zero_d   = 1'b0;
            err_d    = 1'b1;
          end else begin
            result_d = alu_res;
            zero_d   = alu_zero;
            err_d    = 1'b0;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) && owner_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed-vector bench for alu_share_ctrl
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 0, resp1_ready = 0;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err, busy;

  int vectors = 0;
  int miscompares = 0;

  alu_share_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one request on a port; reports accept wait, latency and the returned response.
  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, output int wait_n, output int lat,
                       output logic [31:0] res, output logic z, output logic e);
    wait_n = -1; lat = -1; res = 'x; z = 1'bx; e = 1'bx;
    @(negedge clk);
    if (!port) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else       begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    for (int i = 0; i < 10; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) begin wait_n = i; break; end
      @(negedge clk);
    end
    if (wait_n < 0) begin req0_valid = 0; req1_valid = 0; return; end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    for (int k = 1; k < 40; k++) begin
      #1;
      if (port ? resp1_valid : resp0_valid) begin lat = k; break; end
      @(negedge clk);
    end
    if (lat < 0) return;
    res = resp_result; z = resp_zero; e = resp_err;
    if (port) resp1_ready = 1; else resp0_ready = 1;
    @(negedge clk);
    resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    vectors++;
    if ({busy, resp0_valid, resp1_valid, req0_ready, req1_ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, resp0_valid, resp1_valid, req0_ready, req1_ready});
    end
    vectors++;
    if ({resp_result, resp_zero, resp_err} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %h/%b/%b expected 0/0/0", resp_result, resp_zero, resp_err);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_add();
    int w, l; logic [31:0] r; logic z, e;
    issue(0, 32'd5, 32'd7, ALU_ADD, w, l, r, z, e);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL add_accept: got %0d expected 0", w); end
    vectors++; if (l !== 2) begin miscompares++; $display("FAIL add_latency: got %0d expected 2", l); end
    vectors++; if (r !== 32'd12) begin miscompares++; $display("FAIL add_result: got %h expected c", r); end
    vectors++; if ({z, e} !== 2'b00) begin miscompares++; $display("FAIL add_flags: got %b%b expected 00", z, e); end
  endtask

  task automatic test_back_to_back();
    int got, lat; logic exp_g; logic [31:0] exp_r;
    apply_reset();
    @(negedge clk);
    req0_valid = 1; req0_a = 32'd9;  req0_b = 32'd9;  req0_op = ALU_SUB;
    req1_valid = 1; req1_a = 32'h0F; req1_b = 32'hF0; req1_op = ALU_OR;
    exp_g = 1'b0;
    for (int t = 0; t < 10; t++) begin
      got = -1;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (req0_ready) begin got = 0; break; end
        if (req1_ready) begin got = 1; break; end
        @(negedge clk);
      end
      vectors++;
      if (got !== int'(exp_g)) begin
        miscompares++; $display("FAIL b2b_grant[%0d]: got %0d expected %0d", t, got, exp_g);
      end
      if (got < 0) break;
      @(posedge clk);
      @(negedge clk);
      lat = -1;
      for (int k = 1; k < 10; k++) begin
        #1;
        if (exp_g ? resp1_valid : resp0_valid) begin lat = k; break; end
        @(negedge clk);
      end
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d expected 2", t, lat); end
      exp_r = exp_g ? 32'hFF : 32'h0;
      vectors++;
      if (resp_result !== exp_r) begin
        miscompares++; $display("FAIL b2b_result[%0d]: got %h expected %h", t, resp_result, exp_r);
      end
      vectors++;
      if (resp_zero !== !exp_g) begin
        miscompares++; $display("FAIL b2b_zero[%0d]: got %b expected %b", t, resp_zero, !exp_g);
      end
      if (exp_g) resp1_ready = 1; else resp0_ready = 1;
      @(negedge clk);
      resp0_ready = 0; resp1_ready = 0;
      exp_g = !exp_g;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_mul_div();
    int w, l; logic [31:0] r; logic z, e;
    issue(1, 32'd6, 32'd7, ALU_MUL, w, l, r, z, e);
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL mul_latency: got %0d expected 3", l); end
    vectors++; if (r !== 32'd42) begin miscompares++; $display("FAIL mul_result: got %0d expected 42", r); end
    issue(0, 32'd100, 32'd7, ALU_DIV, w, l, r, z, e);
    vectors++; if (l !== 5) begin miscompares++; $display("FAIL div_latency: got %0d expected 5", l); end
    vectors++; if (r !== 32'd14) begin miscompares++; $display("FAIL div_result: got %0d expected 14", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL div_err: got %b expected 0", e); end
  endtask

  task automatic test_div_zero();
    int w, l; logic [31:0] r; logic z, e;
    issue(0, 32'd10, 32'd0, ALU_DIV, w, l, r, z, e);
    vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_result: got %h expected ffffffff", r); end
    vectors++; if ({z, e} !== 2'b01) begin miscompares++; $display("FAIL div0_flags: got %b%b expected 01", z, e); end
    vectors++; if (l !== 5) begin miscompares++; $display("FAIL div0_latency: got %0d expected 5", l); end
    issue(1, 32'd1, 32'd1, ALU_ADD, w, l, r, z, e);
    vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL post_div0_result: got %h expected 2", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL post_div0_err: got %b expected 0", e); end
    issue(0, 32'd3, 32'd4, 4'b0011, w, l, r, z, e);
    vectors++; if (r !== 32'd7 || l !== 2) begin miscompares++; $display("FAIL undef_op: got %h lat %0d expected 7 lat 2", r, l); end
    issue(1, 32'd3, 32'd4, 4'b1111, w, l, r, z, e);
    vectors++; if (r !== 32'd7 || e !== 1'b0) begin miscompares++; $display("FAIL undef_op_f: got %h err %b expected 7 err 0", r, e); end
    issue(1, 32'd1, 32'd5 << 6, ALU_SLL, w, l, r, z, e);
    vectors++; if (r !== 32'd32) begin miscompares++; $display("FAIL sll: got %h expected 20", r); end
    issue(0, 32'h8000_0000, 32'd4 << 6, ALU_SRA, w, l, r, z, e);
    vectors++; if (r !== 32'hF800_0000) begin miscompares++; $display("FAIL sra: got %h expected f8000000", r); end
  endtask

  task automatic test_hold();
    int l;
    @(negedge clk);
    req0_valid = 1; req0_a = 32'd2; req0_b = 32'd3; req0_op = ALU_ADD;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL hold_accept: got %b expected 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    l = -1;
    for (int k = 1; k < 10; k++) begin
      #1;
      if (resp0_valid) begin l = k; break; end
      @(negedge clk);
    end
    vectors++; if (l !== 2) begin miscompares++; $display("FAIL hold_latency: got %0d expected 2", l); end
    req1_valid = 1; req1_a = 32'd10; req1_b = 32'd20; req1_op = ALU_ADD;
    resp1_ready = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      vectors++;
      if (resp_result !== 32'd5) begin miscompares++; $display("FAIL hold_result[%0d]: got %h expected 5", c, resp_result); end
      vectors++;
      if ({resp0_valid, req1_ready, resp1_valid} !== 3'b100) begin
        miscompares++;
        $display("FAIL hold_flags[%0d]: got %b expected 100", c, {resp0_valid, req1_ready, resp1_valid});
      end
    end
    resp1_ready = 0;
    @(negedge clk);
    resp0_ready = 1;
    #1;
    vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL ack_cycle_ready: got %b expected 0", req1_ready); end
    @(negedge clk);
    resp0_ready = 0;
    #1;
    vectors++;
    if ({resp0_valid, req1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL after_ack: got %b expected 01", {resp0_valid, req1_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    l = -1;
    for (int k = 1; k < 10; k++) begin
      #1;
      if (resp1_valid) begin l = k; break; end
      @(negedge clk);
    end
    vectors++;
    if (l !== 2 || resp_result !== 32'd30) begin
      miscompares++; $display("FAIL waited_req1: got %h lat %0d expected 1e lat 2", resp_result, l);
    end
    resp1_ready = 1;
    @(negedge clk);
    resp1_ready = 0;
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req0_valid = 1; req0_a = 32'd100; req0_b = 32'd7; req0_op = ALU_DIV;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL mid_accept: got %b expected 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst_n = 0;
    #1;
    vectors++;
    if ({busy, resp0_valid, resp1_valid, resp_err} !== 4'b0 || resp_result !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %b result %h expected 0000 result 0",
               {busy, resp0_valid, resp1_valid, resp_err}, resp_result);
    end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (resp0_valid || resp1_valid || busy) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mid_no_resp: got %0d active cycles expected 0", seen); end
    req0_valid = 1; req0_op = ALU_ADD;
    req1_valid = 1; req1_op = ALU_ADD;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL mid_prio: got %b expected 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul_div();
    test_div_zero();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Multi-cycle controller that shares one `ALU` datapath instance between two independent requesters (e.g. the integer pipe and a debug/test port). It arbitrates requests round-robin, captures operands, and holds the operation for a per-opcode latency (modelling multi-cycle multiply and divide). It then registers the result and returns it to the winning requester over a valid/ready response channel. Divide-by-zero is intercepted and flagged.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: EXEC cycles for op `4'b0101` (mult), range 1–15.
- `DIV_CYCLES`, default 4: EXEC cycles for op `4'b1011` (div), range 1–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req1_a`  in  32  operand a.
- `req0_b`, `req1_b`  in  32  operand b (shift amount in `b[10:6]`).
- `req0_op`, `req1_op`  in  4  ALU control code.
- `resp0_valid`, `resp1_valid`  out  1  result available.
- `resp0_ready`, `resp1_ready`  in  1  requester takes result.
- `resp_result`  out  32  result, shared by both response channels.
- `resp_zero`  out  1  result == 0.
- `resp_err`  out  1  divide by zero.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = `req0` if only `req0_valid`; `req1` if only `req1_valid`; `prio` requester if both.
  - `reqN_ready` = (state==IDLE) && grant==N. Ready depends combinationally on valid.
  - On accept: latch a, b, op and the owner id; load the latency counter; go to EXEC; set `prio` to the non-granted requester.
- EXEC:
  - The `ALU` is driven only from the latched operand registers.
  - Counter loads 1 for every op except mult (`MUL_CYCLES`) and div (`DIV_CYCLES`). It decrements each EXEC cycle.
  - In the cycle where the counter equals 1: register `resp_result`, `resp_zero` and `resp_err`, then go to RESP.
- Divide by zero (op `1011`, b==0): `resp_result`=32'hFFFF_FFFF, `resp_zero`=0, `resp_err`=1. `resp_err`=0 for all other ops.
- Undefined op codes (`0011`, `1101`–`1111`) execute as add (ALU default) with 1-cycle latency, no error.
- RESP:
  - `respN_valid`=1 only for the owner.
  - `resp_result`, `resp_zero` and `resp_err` are stable while valid.
  - On `respN_valid && respN_ready`: go to IDLE. No new request is accepted in this same cycle.
- `resp_ready` of the non-owner is ignored. Requests arriving during EXEC or RESP wait with ready=0.

## Timing
- Reset (async assert, sync-safe deassert):
  - State = IDLE, `prio`=0, counter=0.
  - All `reqN_ready`=0 unless in IDLE with valid; all `respN_valid`=0.
  - `resp_result`=0, `resp_zero`=0, `resp_err`=0, `busy`=0.
- Reset mid-EXEC or mid-RESP: the operation is dropped, no response is issued, and `prio` returns to 0.
- Latency, accept edge to first `resp_valid` cycle: L+1 cycles, where L is the EXEC cycle count. Plain ops: accept at cycle 0, `resp_valid` at cycle 2.
- Minimum issue interval per transaction: L+2 cycles (accept, L×EXEC, ≥1 RESP).
- Back-to-back contention: if both requesters stay valid, grants strictly alternate.
- The counter never wraps: MUL_CYCLES and DIV_CYCLES of 0 are illegal, and the counter is loaded only in IDLE.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_MUL`, `ALU_SUB`, `ALU_SLT`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_DIV`, `ALU_NOR`.
  - FSM state encoding, 2 bits.
  - `DIV0_RESULT` = 32'hFFFF_FFFF.
- One sub-module: the existing `ALU` (inputs a, b, alu_control; outputs zero, alu_result), instantiated once and fed from the operand registers.
- The latency-select function lives locally in this block.

## Test plan
- Reset then idle: check `busy`=0, both `resp_valid`=0, `resp_result`=0. Then `req0` add a=5, b=7 → `req0_ready` at cycle 0, `resp0_valid` at cycle 2, result=12, zero=0.
- Both valid at once after reset, `req0` sub 9−9 and `req1` or 0x0F|0xF0 → `req0` first with result 0, zero=1. Then `req1` with result 0xFF. Grants alternate over 4 further back-to-back pairs.
- `req1` mult a=6, b=7 with MUL_CYCLES=2 → `resp1_valid` 3 cycles after accept, result=42. Div 100/7 with DIV_CYCLES=4 → `resp_valid` after 5 cycles, result=14.
- Div a=10, b=0 → result=0xFFFFFFFF, `resp_err`=1, zero=0. The next add 1+1 gives `resp_err`=0.
- Hold `resp0_ready`=0 for 5 cycles while `req1_valid`=1 → result stays stable, `req1_ready` stays 0. `resp1_ready` asserted meanwhile has no effect.
- Assert `rst_n`=0 during the 2nd DIV EXEC cycle → all outputs reset immediately, no response follows, and the next simultaneous requests grant `req0`.
